// File: rtl/computer_run_ctrl.sv
// Boot/run sequencer for the RV32I computer core: host load port, reset hold, run timing, dmem ownership.
// Optional watchdog when RUN_CTRL_WATCHDOG_EN is defined (RUN ends with timeout after MAX_CYCLES).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | core held in reset, host owns imem/dmem
// RST_HOLD | core held in reset for RST_CYCLES cycles after START
// RUN      | core released, core owns dmem, cycles counted until halt
// DONE     | core stopped but not reset, host owns dmem again
module computer_run_ctrl #(
    parameter int ADDR_BITS  = 16,
    parameter int RST_CYCLES = 5,
    parameter int MAX_CYCLES = 50000,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 host_cmd_valid,
    output logic                 host_cmd_ready,
    input  logic [1:0]           host_cmd_op,
    input  logic [ADDR_BITS-1:0] host_cmd_addr,
    input  logic [31:0]          host_cmd_wdata,
    output logic                 host_rsp_valid,
    output logic [31:0]          host_rsp_data,
    output logic                 imem_we,
    output logic [ADDR_BITS-1:0] imem_waddr,
    output logic [31:0]          imem_wdata,
    input  logic                 core_dmem_re,
    input  logic [ADDR_BITS-1:0] core_dmem_raddr,
    input  logic [ADDR_BITS-1:0] core_dmem_waddr,
    input  logic [31:0]          core_dmem_wdata,
    input  logic                 core_dmem_we,
    output logic                 dmem_re,
    output logic [ADDR_BITS-1:0] dmem_raddr,
    output logic [ADDR_BITS-1:0] dmem_waddr,
    output logic [31:0]          dmem_wdata,
    output logic                 dmem_we,
    input  logic [31:0]          dmem_rdata,
    output logic                 core_reset,
    input  logic                 core_halt,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycle_count
);

    typedef enum logic [1:0] {S_IDLE, S_RST_HOLD, S_RUN, S_DONE} state_t;

    localparam logic [1:0] OP_WR_IMEM = 2'd0;
    localparam logic [1:0] OP_WR_DMEM = 2'd1;
    localparam logic [1:0] OP_RD_DMEM = 2'd2;
    localparam logic [1:0] OP_START   = 2'd3;

    localparam int HOLD_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_CYCLES - 1);

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              accept, start_acc, hold_tc, cnt_sat;

    assign accept    = host_cmd_valid & host_cmd_ready;
    assign start_acc = accept & (host_cmd_op == OP_START);
    assign hold_tc   = (hold_cnt == '0);
    assign cnt_sat   = &cycle_count;

`ifdef RUN_CTRL_WATCHDOG_EN
    // Fire on the increment that would bring the count to MAX_CYCLES, so RUN lasts exactly MAX_CYCLES.
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MAX_CYCLES - 1);
    logic wdog_hit;
    assign wdog_hit = (cycle_count == WDOG_LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start_acc) state_nxt = S_RST_HOLD;
            S_RST_HOLD:     if (hold_tc) state_nxt = S_RUN;
            S_RUN: begin
                if (core_halt) state_nxt = S_DONE;
`ifdef RUN_CTRL_WATCHDOG_EN
                else if (wdog_hit) state_nxt = S_DONE;
`endif
            end
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        host_cmd_ready = (state == S_IDLE) || (state == S_DONE);
        core_reset     = (state == S_IDLE) || (state == S_RST_HOLD);
        busy           = (state == S_RST_HOLD) || (state == S_RUN);
        done           = (state == S_DONE);
    end

    // Reset hold timer: loaded at START, terminal count at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                hold_cnt <= '0;
        else if (start_acc)                        hold_cnt <= HOLD_LOAD;
        else if (state == S_RST_HOLD && !hold_tc)  hold_cnt <= hold_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         cycle_count <= '0;
        else if (start_acc)                                 cycle_count <= '0;
        else if (state == S_RUN && !core_halt && !cnt_sat)  cycle_count <= cycle_count + 1'b1;
    end

`ifdef RUN_CTRL_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        timeout <= 1'b0;
        else if (start_acc)                                timeout <= 1'b0;
        else if (state == S_RUN && !core_halt && wdog_hit) timeout <= 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // Read data comes straight from the sync RAM; only the valid strobe is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) host_rsp_valid <= 1'b0;
        else        host_rsp_valid <= accept & (host_cmd_op == OP_RD_DMEM);
    end

    assign host_rsp_data = dmem_rdata;
    assign imem_we       = accept & (host_cmd_op == OP_WR_IMEM);
    assign imem_waddr    = host_cmd_addr;
    assign imem_wdata    = host_cmd_wdata;

    always_comb begin
        if (state == S_RUN) begin
            dmem_re    = core_dmem_re;
            dmem_raddr = core_dmem_raddr;
            dmem_waddr = core_dmem_waddr;
            dmem_wdata = core_dmem_wdata;
            dmem_we    = core_dmem_we;
        end else begin
            dmem_re    = accept & (host_cmd_op == OP_RD_DMEM);
            dmem_raddr = host_cmd_addr;
            dmem_waddr = host_cmd_addr;
            dmem_wdata = host_cmd_wdata;
            dmem_we    = accept & (host_cmd_op == OP_WR_DMEM);
        end
    end

endmodule

// File: tb/tb_computer_run_ctrl.sv
// Bench for computer_run_ctrl: load/read vectors, reset hold, run timing, blocking, async reset, saturation.
module tb_computer_run_ctrl;
    localparam int AB   = 16;
    localparam int RSTC = 5;
    localparam int MAXC = 20;
`ifdef RUN_CTRL_WATCHDOG_EN
    localparam int HALT_AT = 12;
`else
    localparam int HALT_AT = 100;
`endif
    localparam int SAT_EXP = (HALT_AT > 15) ? 15 : HALT_AT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic host_cmd_valid, host_cmd_ready, host_rsp_valid;
    logic [1:0] host_cmd_op;
    logic [AB-1:0] host_cmd_addr;
    logic [31:0] host_cmd_wdata, host_rsp_data;
    logic imem_we;
    logic [AB-1:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic core_dmem_re, core_dmem_we;
    logic [AB-1:0] core_dmem_raddr, core_dmem_waddr;
    logic [31:0] core_dmem_wdata;
    logic dmem_re, dmem_we;
    logic [AB-1:0] dmem_raddr, dmem_waddr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic core_reset, core_halt, busy, done, timeout;
    logic [31:0] cycle_count;

    logic s_ready, s_rsp_valid, s_imem_we, s_dre, s_dwe, s_core_reset, s_busy, s_done, s_timeout;
    logic [31:0] s_rsp_data, s_imem_wdata, s_dwdata;
    logic [AB-1:0] s_imem_waddr, s_draddr, s_dwaddr;
    logic [3:0] s_count;

    computer_run_ctrl #(.ADDR_BITS(AB), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready), .host_cmd_op(host_cmd_op),
        .host_cmd_addr(host_cmd_addr), .host_cmd_wdata(host_cmd_wdata),
        .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_dmem_re(core_dmem_re), .core_dmem_raddr(core_dmem_raddr), .core_dmem_waddr(core_dmem_waddr),
        .core_dmem_wdata(core_dmem_wdata), .core_dmem_we(core_dmem_we),
        .dmem_re(dmem_re), .dmem_raddr(dmem_raddr), .dmem_waddr(dmem_waddr),
        .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
        .core_reset(core_reset), .core_halt(core_halt),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    // Narrow-counter copy sharing all inputs, used only to observe saturation.
    computer_run_ctrl #(.ADDR_BITS(AB), .RST_CYCLES(RSTC), .MAX_CYCLES(15), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(s_ready), .host_cmd_op(host_cmd_op),
        .host_cmd_addr(host_cmd_addr), .host_cmd_wdata(host_cmd_wdata),
        .host_rsp_valid(s_rsp_valid), .host_rsp_data(s_rsp_data),
        .imem_we(s_imem_we), .imem_waddr(s_imem_waddr), .imem_wdata(s_imem_wdata),
        .core_dmem_re(core_dmem_re), .core_dmem_raddr(core_dmem_raddr), .core_dmem_waddr(core_dmem_waddr),
        .core_dmem_wdata(core_dmem_wdata), .core_dmem_we(core_dmem_we),
        .dmem_re(s_dre), .dmem_raddr(s_draddr), .dmem_waddr(s_dwaddr),
        .dmem_wdata(s_dwdata), .dmem_we(s_dwe), .dmem_rdata(dmem_rdata),
        .core_reset(s_core_reset), .core_halt(core_halt),
        .busy(s_busy), .done(s_done), .timeout(s_timeout), .cycle_count(s_count)
    );

    // Sync-read data RAM model.
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (dmem_we) ram[dmem_waddr[7:0]] <= dmem_wdata;
        if (dmem_re) dmem_rdata <= ram[dmem_raddr[7:0]];
    end

    int n_checks = 0;
    int n_err = 0;
    logic [31:0] shadow [0:255];
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && host_rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL rsp_unexpected: got data 0x%0h with no read outstanding", host_rsp_data);
            end else begin
                chk("rsp_data", {32'b0, host_rsp_data}, {32'b0, exp_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [31:0] wdata;
        bit          e_imem;
        bit          e_dwe;
        bit          e_dre;
    } vec_t;

    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d,
                         input bit e_imem, input bit e_dwe, input bit e_dre);
        int k;
        host_cmd_valid = 1'b1;
        host_cmd_op    = op;
        host_cmd_addr  = a;
        host_cmd_wdata = d;
        k = 0;
        @(negedge clk);
        while (!host_cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready", {63'b0, host_cmd_ready}, 64'd1);
        chk("imem_we", {63'b0, imem_we}, {63'b0, e_imem});
        chk("dmem_we", {63'b0, dmem_we}, {63'b0, e_dwe});
        chk("dmem_re", {63'b0, dmem_re}, {63'b0, e_dre});
        if (e_imem) begin
            chk("imem_waddr", {48'b0, imem_waddr}, {48'b0, a});
            chk("imem_wdata", {32'b0, imem_wdata}, {32'b0, d});
        end
        if (e_dwe) chk("dmem_waddr", {48'b0, dmem_waddr}, {48'b0, a});
        if (e_dre) chk("dmem_raddr", {48'b0, dmem_raddr}, {48'b0, a});
        if (op == 2'd2) exp_q.push_back(shadow[a[7:0]]);
        if (op == 2'd1) shadow[a[7:0]] = d;
        @(posedge clk);
        #1 host_cmd_valid = 1'b0;
    endtask

    // Leaves the caller at the negedge of the first RUN cycle.
    task automatic wait_run();
        int k;
        k = 0;
        @(negedge clk);
        while (core_reset && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("enter_run", {63'b0, core_reset}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    vec_t vecs [6];

    initial begin
        vecs[0] = '{2'd0, 16'd0, 32'h0050_0093, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{2'd1, 16'd3, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{2'd2, 16'd3, 32'h0,         1'b0, 1'b0, 1'b1};
        vecs[3] = '{2'd1, 16'd5, 32'h1234_5678, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{2'd2, 16'd5, 32'h0,         1'b0, 1'b0, 1'b1};
        vecs[5] = '{2'd2, 16'd3, 32'h0,         1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 32'h0;
            shadow[i] = 32'h0;
        end

        rst_n = 1'b0;
        host_cmd_valid = 1'b0; host_cmd_op = 2'd0; host_cmd_addr = '0; host_cmd_wdata = '0;
        core_dmem_re = 1'b0; core_dmem_we = 1'b0; core_dmem_raddr = '0; core_dmem_waddr = '0;
        core_dmem_wdata = '0; core_halt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_core_reset", {63'b0, core_reset}, 64'd1);
        chk("rst_ready", {63'b0, host_cmd_ready}, 64'd1);
        chk("rst_status", {60'b0, busy, done, timeout, host_rsp_valid}, 64'd0);
        chk("rst_strobes", {61'b0, imem_we, dmem_re, dmem_we}, 64'd0);
        chk("rst_count", {32'b0, cycle_count}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Host loads in IDLE, back-to-back, reads in order.
        for (int i = 0; i < 6; i++)
            issue(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].e_imem, vecs[i].e_dwe, vecs[i].e_dre);

        // Read immediately followed by START: response still delivered during reset hold.
        issue(2'd2, 16'd5, 32'h0, 1'b0, 1'b0, 1'b1);
        issue(2'd3, 16'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < RSTC; i++) begin
            @(negedge clk);
            chk("hold_core_reset", {63'b0, core_reset}, 64'd1);
            chk("hold_busy_ready", {62'b0, busy, host_cmd_ready}, 64'd2);
        end
        @(negedge clk);
        chk("run_core_reset", {63'b0, core_reset}, 64'd0);

        core_dmem_we = 1'b1; core_dmem_waddr = 16'd200; core_dmem_wdata = 32'hCAFE_0001;
        core_dmem_re = 1'b1; core_dmem_raddr = 16'd201;
        #1;
        chk("mux_we", {63'b0, dmem_we}, 64'd1);
        chk("mux_waddr", {48'b0, dmem_waddr}, 64'd200);
        chk("mux_wdata", {32'b0, dmem_wdata}, 64'hCAFE_0001);
        chk("mux_re_raddr", {47'b0, dmem_re, dmem_raddr}, {47'b0, 1'b1, 16'd201});

        repeat (HALT_AT) @(posedge clk);
        #1 core_halt = 1'b1;
        @(posedge clk);
        #1 core_halt = 1'b0;
        @(negedge clk);
        chk("done_flag", {63'b0, done}, 64'd1);
        chk("done_count", {32'b0, cycle_count}, HALT_AT);
        chk("done_ready_busy", {61'b0, host_cmd_ready, busy, timeout}, 64'd4);
        chk("done_core_reset", {63'b0, core_reset}, 64'd0);
        chk("done_core_blocked", {62'b0, dmem_we, dmem_re}, 64'd0);
        chk("sat_count", {60'b0, s_count}, SAT_EXP);
        core_dmem_we = 1'b0; core_dmem_re = 1'b0;
        @(posedge clk);
        #1;
        issue(2'd2, 16'd3, 32'h0, 1'b0, 1'b0, 1'b1);
        issue(2'd1, 16'd7, 32'h7777_0007, 1'b0, 1'b1, 1'b0);
        issue(2'd2, 16'd7, 32'h0, 1'b0, 1'b0, 1'b1);

        // Long run: watchdog timeout, or still running without it.
        issue(2'd3, 16'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        wait_run();
`ifdef RUN_CTRL_WATCHDOG_EN
        repeat (MAXC) @(posedge clk);
        @(negedge clk);
        chk("wdog_done_timeout", {62'b0, done, timeout}, 64'd3);
        chk("wdog_count", {32'b0, cycle_count}, MAXC);
        chk("wdog_ready", {63'b0, host_cmd_ready}, 64'd1);
`else
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("long_run_state", {60'b0, busy, done, timeout, host_cmd_ready}, 64'd8);
        chk("long_run_count", {32'b0, cycle_count}, 64'd1000);
        core_halt = 1'b1;
        @(negedge clk);
        chk("long_run_halt", {62'b0, done, timeout}, 64'd2);
        chk("long_run_frozen", {32'b0, cycle_count}, 64'd1000);
        core_halt = 1'b0;
`endif
        @(posedge clk);
        #1;

        // Command held during RUN is accepted on the first DONE cycle.
        issue(2'd3, 16'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        wait_run();
        host_cmd_valid = 1'b1; host_cmd_op = 2'd0; host_cmd_addr = 16'd9; host_cmd_wdata = 32'h0BAD_F00D;
        for (int i = 0; i < 10; i++) begin
            chk("run_hold_blocked", {61'b0, host_cmd_ready, imem_we, dmem_we}, 64'd0);
            @(negedge clk);
        end
        core_halt = 1'b1;
        @(negedge clk);
        chk("held_accept", {62'b0, host_cmd_ready, imem_we}, 64'd3);
        chk("held_waddr_wdata", {imem_waddr[15:0], imem_wdata, 16'b0}, {16'd9, 32'h0BAD_F00D, 16'b0});
        chk("held_count", {31'b0, timeout, cycle_count}, 64'd10);
        @(posedge clk);
        #1 host_cmd_valid = 1'b0; core_halt = 1'b0;

        // Async reset mid-run, then a fresh run counts from zero.
        issue(2'd3, 16'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        wait_run();
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_core_reset_ready", {62'b0, core_reset, host_cmd_ready}, 64'd3);
        chk("arst_status", {61'b0, busy, done, timeout}, 64'd0);
        chk("arst_count", {32'b0, cycle_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(2'd3, 16'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        wait_run();
        repeat (7) @(negedge clk);
        core_halt = 1'b1;
        @(negedge clk);
        chk("rerun_done", {63'b0, done}, 64'd1);
        chk("rerun_count", {32'b0, cycle_count}, 64'd7);
        core_halt = 1'b0;
        repeat (3) @(negedge clk);

        chk("rsp_queue_empty", exp_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
